// File: rtl/ce_pkg.sv
// Shared constants and write-side state encoding for the ce frame FIFO.
package ce_pkg;

  localparam int WDATA_DEF = 16;
  localparam int AW_DEF    = 11;
  localparam int FFTPTS_W  = 12;

  // One stored entry is {sop, eop, real, imag}.
  function automatic int entry_w(input int w);
    return 2 * w + 2;
  endfunction

  localparam int ENTRY_W = 2 * WDATA_DEF + 2;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_RECV    = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_t;

endpackage

// File: rtl/ce_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) read.
module ce_sdp_ram #(
  parameter int WIDTH      = 34,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wa,
  input  logic [WIDTH-1:0]      wd,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] ra,
  output logic [WIDTH-1:0]      rd
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/ce_frame_fifo.sv
// Store-and-forward frame FIFO: only complete, error-free frames of exactly
// fftpts_in beats are released to the source side; others are rolled back.
module ce_frame_fifo
  import ce_pkg::*;
#(
  parameter int wData = WDATA_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                clk,
  input  logic                rst_n_sync,
  input  logic                sink_valid,
  output logic                sink_ready,
  input  logic [1:0]          sink_error,
  input  logic                sink_sop,
  input  logic                sink_eop,
  input  logic [wData-1:0]    sink_real,
  input  logic [wData-1:0]    sink_imag,
  input  logic [FFTPTS_W-1:0] fftpts_in,
  output logic                source_valid,
  input  logic                source_ready,
  output logic [1:0]          source_error,
  output logic                source_sop,
  output logic                source_eop,
  output logic [wData-1:0]    source_real,
  output logic [wData-1:0]    source_imag,
  output logic [FFTPTS_W-1:0] fftpts_out,
  output logic                frame_drop,
  output logic [15:0]         drop_cnt
);

  localparam int EW = entry_w(wData);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  wr_state_t            state, state_nxt;
  logic [AW:0]          wr_ptr, wr_ptr_nxt, wr_cmt, wr_cmt_nxt, rd_ptr, base;
  logic [FFTPTS_W-1:0]  cnt, cnt_nxt, beat_n;
  logic                 err, err_nxt, beat_err, frame_err;
  logic                 accept, drop, we, full;
  logic [AW-1:0]        wa;
  logic [EW-1:0]        wd, rq, ob0, ob1;
  logic                 vld0, vld1, rd_en, rd_pend, pop;
  logic [1:0]           avail;

  function automatic logic ptr_full(input logic [AW:0] w, input logic [AW:0] r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

  assign accept       = sink_valid & sink_ready;
  assign sink_ready   = ~full;
  assign beat_err     = (sink_error != 2'b00);
  assign wd           = {sink_sop, sink_eop, sink_real, sink_imag};
  assign source_error = 2'b00;
  assign fftpts_out   = fftpts_in;

  // Write FSM next state, speculative/commit pointers and drop decision
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    wr_cmt_nxt = wr_cmt;
    cnt_nxt    = cnt;
    err_nxt    = err;
    drop       = 1'b0;
    we         = 1'b0;
    // A sop always (re)starts the frame at the last committed boundary.
    base       = sink_sop ? wr_cmt : wr_ptr;
    beat_n     = sink_sop ? {{(FFTPTS_W-1){1'b0}}, 1'b1} : cnt + {{(FFTPTS_W-1){1'b0}}, 1'b1};
    frame_err  = sink_sop ? beat_err : (err | beat_err);
    wa         = base[AW-1:0];
    if (accept && (sink_sop || (state == WR_RECV))) begin
      we   = 1'b1;
      drop = sink_sop && (state == WR_RECV);
      if (sink_eop) begin
        state_nxt = WR_IDLE;
        if ((beat_n == fftpts_in) && !frame_err) begin
          wr_ptr_nxt = base + PTR_ONE;
          wr_cmt_nxt = base + PTR_ONE;
        end else begin
          wr_ptr_nxt = wr_cmt;
          drop       = 1'b1;
        end
      end else if (beat_n == fftpts_in) begin
        wr_ptr_nxt = wr_cmt;
        drop       = 1'b1;
        state_nxt  = WR_DISCARD;
      end else begin
        wr_ptr_nxt = base + PTR_ONE;
        cnt_nxt    = beat_n;
        err_nxt    = frame_err;
        state_nxt  = WR_RECV;
      end
    end else if (accept && (state == WR_DISCARD) && sink_eop) begin
      state_nxt = WR_IDLE;
    end else begin
      case (state)
        WR_IDLE, WR_RECV, WR_DISCARD: state_nxt = state;
        default:                      state_nxt = WR_IDLE;
      endcase
    end
  end

  // Write-side registers, full flag and drop statistics
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state      <= WR_IDLE;
      wr_ptr     <= '0;
      wr_cmt     <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
      frame_drop <= 1'b0;
      drop_cnt   <= 16'd0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      wr_cmt     <= wr_cmt_nxt;
      cnt        <= cnt_nxt;
      err        <= err_nxt;
      // Uses the pre-pop read pointer: a pop frees space one cycle late.
      full       <= ptr_full(wr_ptr_nxt, rd_ptr);
      frame_drop <= drop;
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  ce_sdp_ram #(
    .WIDTH      (EW),
    .DEPTH_LOG2 (AW)
  ) u_ram (
    .clk (clk),
    .we  (we),
    .wa  (wa),
    .wd  (wd),
    .re  (rd_en),
    .ra  (rd_ptr[AW-1:0]),
    .rd  (rq)
  );

  assign pop   = vld0 & source_ready;
  assign avail = {1'b0, vld0} + {1'b0, vld1} + {1'b0, rd_pend};
  // Issue a read only if the skid buffer can absorb it when it lands.
  assign rd_en = (rd_ptr != wr_cmt) && (avail <= ({1'b0, pop} + 2'd1));

  // Read pointer and in-flight read tracking
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr + {{AW{1'b0}}, rd_en};
      rd_pend <= rd_en;
    end
  end

  // Two-entry output skid buffer; ob0 drives the source port
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      ob0  <= '0;
      ob1  <= '0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
    end else begin
      case ({rd_pend, pop})
        2'b11: begin
          if (vld1) begin
            ob0 <= ob1;
            ob1 <= rq;
          end else begin
            ob0 <= rq;
          end
        end
        2'b01: begin
          ob0  <= ob1;
          vld0 <= vld1;
          vld1 <= 1'b0;
        end
        2'b10: begin
          if (!vld0) begin
            ob0  <= rq;
            vld0 <= 1'b1;
          end else begin
            ob1  <= rq;
            vld1 <= 1'b1;
          end
        end
        default: begin
          ob0 <= ob0;
        end
      endcase
    end
  end

  assign source_valid = vld0;
  assign {source_sop, source_eop, source_real, source_imag} = ob0;

endmodule

// File: doc/ce_frame_fifo.md
Name: ce_frame_fifo

Overview:
- Store-and-forward frame FIFO directly upstream of ce_top; accepts FFT-output Avalon-ST frames and feeds ce_top's sink port.
- Forwards only complete, well-formed frames, so ce_LS always sees a contiguous frame: sop to eop, exactly fftpts_in beats, sink_error == 0 on every beat.
- Malformed frames are rolled back and dropped. Backpressure on both sides.

Parameters:
wData, 16, width of real and imag samples
AW, 11, address width; storage is 2^AW samples, and one max-size frame (2048) must fit

Ports:
clk  in  1  clock
rst_n_sync  in  1  reset, asynchronous assert, active-low
sink_valid  in  1  input beat valid
sink_ready  out  1  high when storage is not full
sink_error  in  2  nonzero marks the beat, and so the frame, as bad
sink_sop  in  1  first beat of frame
sink_eop  in  1  last beat of frame
sink_real  in  wData  sample real part
sink_imag  in  wData  sample imag part
fftpts_in  in  12  frame length (power of 2, at most 2^AW); static while frames are in flight
source_valid  out  1  output beat valid
source_ready  in  1  downstream ready; ready latency 0
source_error  out  2  always 0
source_sop  out  1  first beat of frame
source_eop  out  1  last beat of frame
source_real  out  wData  sample real part
source_imag  out  wData  sample imag part
fftpts_out  out  12  equals fftpts_in (combinational)
frame_drop  out  1  one-cycle pulse per dropped frame
drop_cnt  out  16  dropped-frame count, saturates at 0xFFFF

Behaviour:
- Reset values:
  - All outputs 0, except sink_ready = 1.
  - All pointers 0; write FSM in IDLE.
- Storage:
  - Each entry is {sop, eop, real, imag}, 2*wData+2 bits, held in a simple dual-port RAM with 1-cycle read.
  - Pointers are AW+1 bits; full/empty use the MSB-differ rule.
- Write pointers:
  - wr_ptr: speculative write pointer.
  - wr_cmt: last committed frame boundary.
- Occupancy and ready:
  - Occupancy = wr_ptr - rd_ptr.
  - sink_ready = (occupancy != 2^AW).
  - A beat is accepted when sink_valid & sink_ready.
- Write FSM: IDLE, RECV, DISCARD.
  - IDLE, accepted beat with sop=1:
    - Write the beat; cnt <= 1.
    - If eop=1 and fftpts_in == 1, commit; otherwise go to RECV.
  - IDLE, accepted beat with sop=0: ignore the beat; no drop counted.
  - RECV, accepted beat:
    - Write the beat; cnt++.
    - sop=1 (restart): roll back wr_ptr <= wr_cmt, count one drop, then treat the beat as a new sop (cnt <= 1).
    - eop=1 with cnt+1 == fftpts_in and no error seen: commit, i.e. wr_cmt <= wr_ptr+1, go to IDLE.
    - eop=1 otherwise: roll back, drop, go to IDLE.
    - cnt+1 == fftpts_in without eop: roll back, drop, go to DISCARD.
    - sink_error != 0 on any beat: latch the error flag; the check happens at eop.
  - DISCARD:
    - Ignore beats until eop (go to IDLE) or sop (handled exactly as an IDLE sop).
- Rollback and commit:
  - Rollback frees the space immediately; the read side never sees uncommitted entries.
  - frame_drop pulses in the cycle after the deciding beat; drop_cnt increments in the same cycle.
- Read side:
  - Reads only while rd_ptr != wr_cmt.
  - Prefetches into a 2-entry output skid buffer so source_valid can stay high every cycle under source_ready=1.
  - A beat transfers on source_valid & source_ready.
  - source_* fields are held stable while source_valid & !source_ready.
- Latency:
  - Eop accepted at cycle T with empty FIFO and source_ready=1: commit visible at T+1, first source_valid at T+3.
  - After that, 1 beat per cycle.
- Simultaneous events:
  - Commit and read in the same cycle are independent.
  - Read pop and write in the full cycle: sink_ready rises in the next cycle (registered full flag; one-cycle bubble accepted).
- Mid-operation reset: outputs return to reset values asynchronously; all stored and partial frames are lost.

Decomposition:
- ce_pkg: wData default, AW, entry-width localparam, write-FSM state encoding.
- Sub-module ce_sdp_ram (parameterised width/depth, 1-cycle registered read).
- FSM, pointers and skid buffer stay in ce_frame_fifo.

Test Plan:
1. Clean frame: fftpts_in=16, 16 beats with sop/eop, samples 0..15, source_ready=1 -> source_valid first at eop+3; 16 contiguous beats, values 0..15, sop on 0, eop on 15, frame_drop never pulses.
2. Short frame: fftpts_in=16, eop on beat 10 -> no output, frame_drop pulses once, drop_cnt=1. Next good frame is output intact.
3. Error beat: sink_error=2'b01 on beat 5 of 16 -> frame dropped, drop_cnt increments, nothing on source.
4. Sop restart: sop at beat 0, second sop at beat 7, then 16 clean beats -> only the second frame is output; drop_cnt=1.
5. Backpressure/full: AW=4 (16 entries), fftpts_in=16, source_ready=0, send two frames:
   - First frame commits; sink_ready goes 0 once 16 entries are stored.
   - Raise source_ready: first frame drains, the second is accepted and output.
   - No beats are lost or duplicated.
6. Reset mid-frame: rst_n_sync low during beat 8 of an output frame -> all outputs 0 immediately, sink_ready=1 after release, drop_cnt=0, a fresh frame passes.
